// File: rtl/operand_entry_2d.sv
// Keypad operand-entry stage: gathers two 2-digit BCD operands (A, B) for the subtractor.
// Optional AUTO_ADVANCE_EN: advance to the next operand automatically after the second digit.
module operand_entry_2d #(
   parameter logic [3:0] KEY_SUB = 4'hA,
   parameter logic [3:0] KEY_EQ  = 4'hB,
   parameter logic [3:0] KEY_CLR = 4'hC
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [3:0] opa1,
   output logic [3:0] opa0,
   output logic [3:0] opb1,
   output logic [3:0] opb0,
   output logic [1:0] state,
   output logic       ops_valid,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_A    = 2'd0,
      ST_B    = 2'd1,
      ST_DONE = 2'd2,
      ST_BAD  = 2'd3
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] a1_reg, a1_next, a0_reg, a0_next;
   logic [3:0] b1_reg, b1_next, b0_reg, b0_next;
   logic [1:0] cnt_reg, cnt_next;
   logic       done_reg, done_next;
   logic       ops_valid_reg;

   logic       is_digit;
   logic [1:0] cnt_inc;

   assign is_digit = (key_code <= 4'd9);
   assign cnt_inc  = (cnt_reg == 2'd2) ? 2'd2 : cnt_reg + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_A;
         a1_reg        <= 4'd0;
         a0_reg        <= 4'd0;
         b1_reg        <= 4'd0;
         b0_reg        <= 4'd0;
         cnt_reg       <= 2'd0;
         done_reg      <= 1'b0;
         ops_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         a1_reg        <= a1_next;
         a0_reg        <= a0_next;
         b1_reg        <= b1_next;
         b0_reg        <= b0_next;
         cnt_reg       <= cnt_next;
         done_reg      <= done_next;
         ops_valid_reg <= (state_next == ST_DONE);
      end
   end

   always_comb begin
      state_next = state_reg;
      a1_next    = a1_reg;
      a0_next    = a0_reg;
      b1_next    = b1_reg;
      b0_next    = b0_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;

      // The illegal encoding recovers like a clear, independent of key activity
      if (state_reg == ST_BAD || (key_valid && key_code == KEY_CLR)) begin
         state_next = ST_A;
         a1_next    = 4'd0;
         a0_next    = 4'd0;
         b1_next    = 4'd0;
         b0_next    = 4'd0;
         cnt_next   = 2'd0;
      end else if (key_valid) begin
         case (state_reg)
            ST_A: begin
               if (is_digit) begin
                  a1_next  = a0_reg;
                  a0_next  = key_code;
                  cnt_next = cnt_inc;
`ifdef AUTO_ADVANCE_EN
                  if (cnt_reg == 2'd1) begin
                     state_next = ST_B;
                     b1_next    = 4'd0;
                     b0_next    = 4'd0;
                     cnt_next   = 2'd0;
                  end
`endif
               end else if (key_code == KEY_SUB) begin
                  state_next = ST_B;
                  b1_next    = 4'd0;
                  b0_next    = 4'd0;
                  cnt_next   = 2'd0;
               end
            end
            ST_B: begin
               if (is_digit) begin
                  b1_next  = b0_reg;
                  b0_next  = key_code;
                  cnt_next = cnt_inc;
`ifdef AUTO_ADVANCE_EN
                  if (cnt_reg == 2'd1) begin
                     state_next = ST_DONE;
                     done_next  = 1'b1;
                  end
`endif
               end else if (key_code == KEY_EQ) begin
                  state_next = ST_DONE;
                  done_next  = 1'b1;
               end
            end
            ST_DONE: begin
               // A digit after completion starts a fresh A with that digit
               if (is_digit) begin
                  state_next = ST_A;
                  a1_next    = 4'd0;
                  a0_next    = key_code;
                  b1_next    = 4'd0;
                  b0_next    = 4'd0;
                  cnt_next   = 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign opa1      = a1_reg;
   assign opa0      = a0_reg;
   assign opb1      = b1_reg;
   assign opb0      = b0_reg;
   assign state     = state_reg;
   assign ops_valid = ops_valid_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_operand_entry_2d.sv
// Directed bench for operand_entry_2d; expectations follow AUTO_ADVANCE_EN when defined.
module tb_operand_entry_2d;

   logic       clk;
   logic       rst_n;
   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] opa1, opa0, opb1, opb0;
   logic [1:0] state;
   logic       ops_valid;
   logic       done;

   int checks   = 0;
   int failures = 0;
   int done_count = 0;

   localparam logic [3:0] K_SUB = 4'hA;
   localparam logic [3:0] K_EQ  = 4'hB;
   localparam logic [3:0] K_CLR = 4'hC;

   operand_entry_2d dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_code  (key_code),
      .opa1      (opa1),
      .opa0      (opa0),
      .opb1      (opb1),
      .opb0      (opb0),
      .state     (state),
      .ops_valid (ops_valid),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_count++;

   // Called at a negedge; returns at the next negedge with key_valid low
   task automatic press(input logic [3:0] c);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; key_valid = 1'b1; key_code = 4'd5;
      repeat (2) @(negedge clk);
      checks++;
      if ({opa1, opa0, opb1, opb0, state, ops_valid, done} !== 23'd0) begin
         failures++;
         $display("FAIL reset_hold got=%h %h %h %h st=%0d v=%b d=%b want all 0",
                  opa1, opa0, opb1, opb0, state, ops_valid, done);
      end
      key_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({opa1, opa0, opb1, opb0, state, ops_valid, done} !== 23'd0) begin
         failures++;
         $display("FAIL reset_release got=%h %h %h %h st=%0d v=%b d=%b want all 0",
                  opa1, opa0, opb1, opb0, state, ops_valid, done);
      end
      $display("test_reset done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_basic_entry();
      do_reset();
      done_count = 0;
      press(4'd4); press(4'd7); press(K_SUB); press(4'd2); press(4'd9);
`ifdef AUTO_ADVANCE_EN
      checks++;
      if (done !== 1'b1 || state !== 2'd2) begin
         failures++;
         $display("FAIL auto_done got done=%b st=%0d want done=1 st=2", done, state);
      end
      press(K_EQ);
`else
      checks++;
      if (state !== 2'd1 || done !== 1'b0) begin
         failures++;
         $display("FAIL pre_eq got st=%0d done=%b want st=1 done=0", state, done);
      end
      press(K_EQ);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL eq_done got=%b want=1", done);
      end
`endif
      checks++;
      if ({opa1, opa0, opb1, opb0, state, ops_valid} !== {4'd4, 4'd7, 4'd2, 4'd9, 2'd2, 1'b1}) begin
         failures++;
         $display("FAIL basic_ops got=%h%h/%h%h st=%0d v=%b want=47/29 st=2 v=1",
                  opa1, opa0, opb1, opb0, state, ops_valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || done_count != 1) begin
         failures++;
         $display("FAIL done_pulse got done=%b count=%0d want done=0 count=1", done, done_count);
      end
      $display("test_basic_entry done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_done_restart();
      press(4'd6);
      checks++;
      if ({opa1, opa0, opb1, opb0, state, ops_valid, done} !==
          {4'd0, 4'd6, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL done_restart got=%h%h/%h%h st=%0d v=%b d=%b want=06/00 st=0 v=0 d=0",
                  opa1, opa0, opb1, opb0, state, ops_valid, done);
      end
      $display("test_done_restart done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_back_to_back();
      do_reset();
      key_valid = 1'b1;
      key_code = 4'd1; @(negedge clk);
      key_code = 4'd2; @(negedge clk);
      key_code = 4'd3; @(negedge clk);
      key_valid = 1'b0;
      checks++;
`ifdef AUTO_ADVANCE_EN
      if ({opa1, opa0, opb1, opb0, state} !== {4'd1, 4'd2, 4'd0, 4'd3, 2'd1}) begin
         failures++;
         $display("FAIL back_to_back got=%h%h/%h%h st=%0d want=12/03 st=1",
                  opa1, opa0, opb1, opb0, state);
      end
`else
      if ({opa1, opa0, opb1, opb0, state} !== {4'd2, 4'd3, 4'd0, 4'd0, 2'd0}) begin
         failures++;
         $display("FAIL back_to_back got=%h%h/%h%h st=%0d want=23/00 st=0",
                  opa1, opa0, opb1, opb0, state);
      end
`endif
      $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_clear();
      do_reset();
      done_count = 0;
      press(4'd5); press(K_SUB); press(4'd8);
      checks++;
      if ({opa0, opb0, state} !== {4'd5, 4'd8, 2'd1}) begin
         failures++;
         $display("FAIL pre_clear got a0=%h b0=%h st=%0d want a0=5 b0=8 st=1", opa0, opb0, state);
      end
      press(K_CLR);
      @(negedge clk);
      checks++;
      if ({opa1, opa0, opb1, opb0, state, ops_valid} !== 19'd0 || done_count != 0) begin
         failures++;
         $display("FAIL clear got=%h%h/%h%h st=%0d v=%b dcount=%0d want all 0",
                  opa1, opa0, opb1, opb0, state, ops_valid, done_count);
      end
      $display("test_clear done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_ignored();
      do_reset();
      press(K_EQ);
      checks++;
      if ({opa1, opa0, opb1, opb0, state, done} !== 19'd0) begin
         failures++;
         $display("FAIL eq_in_a got=%h%h/%h%h st=%0d d=%b want all 0",
                  opa1, opa0, opb1, opb0, state, done);
      end
      press(4'd3); press(K_EQ); press(4'hD);
      checks++;
      if ({opa1, opa0, opb1, opb0, state} !== {4'd0, 4'd3, 4'd0, 4'd0, 2'd0}) begin
         failures++;
         $display("FAIL ignore_a got=%h%h/%h%h st=%0d want=03/00 st=0",
                  opa1, opa0, opb1, opb0, state);
      end
      press(K_SUB); press(K_SUB); press(4'hE); press(4'hF);
      checks++;
      if ({opa1, opa0, opb1, opb0, state, done} !== {4'd0, 4'd3, 4'd0, 4'd0, 2'd1, 1'b0}) begin
         failures++;
         $display("FAIL ignore_b got=%h%h/%h%h st=%0d d=%b want=03/00 st=1 d=0",
                  opa1, opa0, opb1, opb0, state, done);
      end
      press(4'd5); press(K_EQ); press(4'hD); press(K_SUB); press(K_EQ); press(4'hE);
      checks++;
      if ({opa1, opa0, opb1, opb0, state, ops_valid, done} !==
          {4'd0, 4'd3, 4'd0, 4'd5, 2'd2, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL ignore_done got=%h%h/%h%h st=%0d v=%b d=%b want=03/05 st=2 v=1 d=0",
                  opa1, opa0, opb1, opb0, state, ops_valid, done);
      end
      $display("test_ignored done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_async_reset();
      do_reset();
      press(4'd3); press(4'd1);
`ifndef AUTO_ADVANCE_EN
      press(K_SUB);
`endif
      checks++;
      if ({opa1, opa0, opb1, opb0, state} !== {4'd3, 4'd1, 4'd0, 4'd0, 2'd1}) begin
         failures++;
         $display("FAIL pre_async got=%h%h/%h%h st=%0d want=31/00 st=1",
                  opa1, opa0, opb1, opb0, state);
      end
      key_valid = 1'b1; key_code = 4'd9;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({opa1, opa0, opb1, opb0, state, ops_valid, done} !== 23'd0) begin
         failures++;
         $display("FAIL async_clear got=%h%h/%h%h st=%0d v=%b d=%b want all 0",
                  opa1, opa0, opb1, opb0, state, ops_valid, done);
      end
      key_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({opa1, opa0, opb1, opb0, state} !== 18'd0) begin
         failures++;
         $display("FAIL async_after got=%h%h/%h%h st=%0d want all 0",
                  opa1, opa0, opb1, opb0, state);
      end
      $display("test_async_reset done checks=%0d failures=%0d", checks, failures);
   endtask

   initial begin
      rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
      test_reset();
      test_basic_entry();
      test_done_restart();
      test_back_to_back();
      test_clear();
      test_ignored();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
